// File: rtl/lim_counter_chain_pkg.sv
// Shared constants and types for the limited digit counter chain.
// Holds the stopwatch limit presets and the direction encodings.
package lim_counter_chain_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Digit 0 sits in the LSBs. The hours-tens limit of 3 keeps that digit in 0..2.
  localparam logic [15:0] MMSS_LIMITS   = 16'h6A6A;
  localparam logic [23:0] HHMMSS_LIMITS = 24'h3A6A6A;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_STEP
  } digit_op_e;

endpackage

// File: rtl/lim_digit.sv
// One modulo-L digit register with clear, clamped load and an up/down step.
// A limit field of 0 selects the full 2^DIG_W range.
module lim_digit
  import lim_counter_chain_pkg::*;
#(
  parameter int DIG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [DIG_W-1:0] limit_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [DIG_W-1:0] load_val_i,
  output logic [DIG_W-1:0] value_o,
  output logic             is_max_o,
  output logic             is_min_o
);

  logic [DIG_W-1:0] value_q, value_d;
  logic [DIG_W-1:0] maxVal;
  digit_op_e        op;

  // A zero field wraps to all ones, which is exactly 2^DIG_W - 1.
  assign maxVal   = limit_i - DIG_W'(1);
  assign is_max_o = (value_q == maxVal);
  assign is_min_o = (value_q == '0);
  assign value_o  = value_q;

  always_comb begin
    op = OP_HOLD;
    if (clear_i)     op = OP_CLEAR;
    else if (load_i) op = OP_LOAD;
    else if (en_i)   op = OP_STEP;
  end

  always_comb begin
    value_d = value_q;
    case (op)
      OP_CLEAR: value_d = '0;
      OP_LOAD:  value_d = (load_val_i > maxVal) ? maxVal : load_val_i;
      OP_STEP: begin
        if (dir_i == DIR_UP) value_d = is_max_o ? '0 : value_q + DIG_W'(1);
        else                 value_d = is_min_o ? maxVal : value_q - DIG_W'(1);
      end
      default: value_d = value_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) value_q <= '0;
    else         value_q <= value_d;
  end

endmodule

// File: rtl/lim_counter_chain.sv
// Cascade of NDIG limited digits counting up or down on a tick strobe,
// with wrap or saturate at the chain ends plus wrap pulse and sticky overflow.
module lim_counter_chain
  import lim_counter_chain_pkg::*;
#(
  parameter int                    NDIG     = 4,
  parameter int                    DIG_W    = 4,
  parameter logic [NDIG*DIG_W-1:0] LIMITS   = 16'h6A6A,
  parameter bit                    SATURATE = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tick_i,
  input  logic                  dir_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [NDIG*DIG_W-1:0] load_val_i,
  output logic [NDIG*DIG_W-1:0] digits_o,
  output logic                  wrap_pulse_o,
  output logic                  at_max_o,
  output logic                  at_zero_o,
  output logic                  ovf_o
);

  logic [NDIG-1:0] isMax, isMin, stepEn;
  logic [NDIG:0]   lowerMax, lowerMin;
  logic            countNow, endEvent, holdEnd;
  logic            wrap_q, wrap_d, ovf_q, ovf_d;

  assign lowerMax[0] = 1'b1;
  assign lowerMin[0] = 1'b1;

  assign countNow = tick_i & ~clear_i & ~load_i;
  assign endEvent = countNow & ((dir_i == DIR_UP) ? at_max_o : at_zero_o);
  // Saturating chains freeze every digit on an end-of-range tick.
  assign holdEnd  = SATURATE & endEvent;

  for (genvar g = 0; g < NDIG; g++) begin : gDigit
    assign lowerMax[g+1] = lowerMax[g] & isMax[g];
    assign lowerMin[g+1] = lowerMin[g] & isMin[g];
    assign stepEn[g]     = countNow & ~holdEnd &
                           ((dir_i == DIR_UP) ? lowerMax[g] : lowerMin[g]);

    lim_digit #(.DIG_W(DIG_W)) uDigit (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .limit_i    (LIMITS[g*DIG_W +: DIG_W]),
      .en_i       (stepEn[g]),
      .dir_i      (dir_i),
      .clear_i    (clear_i),
      .load_i     (load_i),
      .load_val_i (load_val_i[g*DIG_W +: DIG_W]),
      .value_o    (digits_o[g*DIG_W +: DIG_W]),
      .is_max_o   (isMax[g]),
      .is_min_o   (isMin[g])
    );
  end

  assign at_max_o  = lowerMax[NDIG];
  assign at_zero_o = lowerMin[NDIG];

  always_comb begin
    wrap_d = endEvent & ~SATURATE;
    ovf_d  = ovf_q;
    if (clear_i)       ovf_d = 1'b0;
    else if (endEvent) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign wrap_pulse_o = wrap_q;
  assign ovf_o        = ovf_q;

endmodule
